alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Downstream stage of the ALU operand/result select path. It captures the N-bit result chosen by the 4-way result multiplexer, together with its carry/overflow side signals.
- Derives per-result NZCV flags and buffers up to two results in a valid/ready skid buffer, so a stalled consumer never drops data.
- Maintains the architectural NZCV flag register and a retired-result counter. It sits between the ALU datapath and writeback.

Parameters:
- N, 64, datapath width of result
- CNT_W, 32, width of retired-result counter

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  synchronous, active-low reset
- i_valid  input  1  upstream result valid
- o_ready  output  1  stage can accept a result this cycle
- i_result  input  N  result from result multiplexer
- i_carry  input  1  carry-out of the selected operation
- i_overflow  input  1  signed overflow of the selected operation
- i_set_flags  input  1  result updates architectural flags on retirement
- o_valid  output  1  o_result/o_flags valid
- i_ready  input  1  downstream accepts output
- o_result  output  N  buffered result
- o_flags  output  4  per-result {N,Z,C,V}
- o_nzcv  output  4  architectural flag register {N,Z,C,V}
- o_count  output  CNT_W  number of results retired

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_rst_n, sampled on the rising edge.
- Reset values: state EMPTY, o_valid=0, o_ready=0, o_result=0, o_flags=0, o_nzcv=0, o_count=0. Skid entry is cleared.
- Ready after reset: o_ready becomes 1 on the first edge with i_rst_n=1.
- Reset mid-operation: drops all buffered entries with no output handshake. Reset overrides every other event in the same cycle.
- Handshake events:
  - in_fire = i_valid & o_ready.
  - out_fire = o_valid & i_ready.
  - i_result/i_carry/i_overflow/i_set_flags are sampled only on in_fire.
  - Output data holds stable while o_valid=1 and i_ready=0.
- Flag derivation, computed on the captured input and stored with the entry:
  - N = i_result[N-1]
  - Z = (i_result == 0)
  - C = i_carry
  - V = i_overflow
- Entry contents: {result, flags, set_flags}. The main entry drives o_result/o_flags.
- States (registered): EMPTY (no entry), ONE (main valid), FULL (main+skid valid).
  - EMPTY: in_fire -> ONE, main<=input.
  - ONE, in_fire & out_fire -> ONE, main<=input.
  - ONE, in_fire & !out_fire -> FULL, skid<=input.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither -> ONE.
  - FULL: in_fire impossible (o_ready=0). out_fire -> ONE, main<=skid. Otherwise hold.
- Output timing:
  - o_valid = (state != EMPTY).
  - o_ready is registered, equal to (next_state != FULL); no combinational path i_ready->o_ready.
  - Latency input->output is 1 cycle when the stage is empty.
  - Throughput is 1 result/cycle while i_ready=1.
- Retirement: on out_fire, o_count <= o_count+1, wrapping modulo 2^CNT_W. If the retiring entry has set_flags=1, o_nzcv <= its flags the same edge; otherwise o_nzcv holds.
- Ordering: results retire strictly in acceptance order. The skid entry never bypasses main.
- Width rule: Z compares all N bits. No sign extension or truncation of result.

Test Plan:
- Reset then single beat (N=64): i_rst_n low 2 cycles -> all outputs 0. Release; next cycle o_ready=1. Then drive i_valid=1, i_result=0x8000_0000_0000_0000, carry=1, ovf=0, set_flags=1, i_ready=1 -> next cycle o_valid=1, o_result same, o_flags=4'b1010. Following edge: o_nzcv=4'b1010, o_count=1.
- Zero result, no flag update: i_result=0, set_flags=0 after o_nzcv=4'b1010 -> o_flags=4'b0100, o_nzcv stays 4'b1010, o_count increments.
- Backpressure: i_ready=0, push values 0x11 then 0x22 on consecutive cycles -> after second accept o_ready=0, o_result=0x11 held. Raise i_ready -> 0x11 then 0x22 retire on consecutive cycles; o_ready=1 the cycle after 0x11 retires.
- Streaming: 8 back-to-back beats 1..8 with i_ready=1 -> outputs 1..8 in order, one per cycle, o_ready never drops, o_count=8.
- Reset mid-operation: FULL with 0xAA/0xBB buffered, assert i_rst_n=0 for one cycle with i_ready=1 -> no retirement. o_valid=0, o_count=0, o_nzcv=0 after that edge.
- Counter wrap (CNT_W=4): retire 17 results -> o_count=1.

Source files
------------

// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle between the ALU result multiplexer, the
// alu_result_stage and the writeback consumer.
//   i_valid/o_ready                           : upstream handshake
//   i_result/i_carry/i_overflow/i_set_flags   : upstream result payload
//   o_valid/i_ready                           : downstream handshake
//   o_result/o_flags                          : buffered result and its {N,Z,C,V}
//   o_nzcv                                    : architectural flag register
//   o_count                                   : retired-result counter
// Modport slave is the stage's view; master is the environment's view.
interface alu_result_stage_if #(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [N-1:0]     i_result;
  logic             i_carry;
  logic             i_overflow;
  logic             i_set_flags;
  logic             o_valid;
  logic             i_ready;
  logic [N-1:0]     o_result;
  logic [3:0]       o_flags;
  logic [3:0]       o_nzcv;
  logic [CNT_W-1:0] o_count;

  modport slave (
    input  i_valid, i_result, i_carry, i_overflow, i_set_flags, i_ready,
    output o_ready, o_valid, o_result, o_flags, o_nzcv, o_count
  );

  modport master (
    output i_valid, i_result, i_carry, i_overflow, i_set_flags, i_ready,
    input  o_ready, o_valid, o_result, o_flags, o_nzcv, o_count
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: captures the selected result with its carry/overflow,
// derives per-result NZCV flags, buffers up to two results in a valid/ready
// skid buffer, and on retirement updates the architectural NZCV register and
// the retired-result counter.
// Ports:
//   i_clk   : clock, all state changes on the rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : alu_result_stage_if.slave (handshakes, payload, status)
module alu_result_stage #(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  alu_result_stage_if.slave     bus
);

  localparam int unsigned FLAG_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [N-1:0]      result;
    logic [FLAG_W-1:0] flags;
    logic              set_flags;
  } entry_t;

  state_t            state_q, state_d;
  entry_t            main_q, main_d;
  entry_t            skid_q, skid_d;
  entry_t            in_entry_c;
  logic [FLAG_W-1:0] nzcv_q, nzcv_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q;
  logic              valid_q;
  logic              in_fire_c;
  logic              out_fire_c;

  assign in_fire_c  = bus.i_valid & ready_q;
  assign out_fire_c = valid_q & bus.i_ready;

  // Incoming entry with flags derived from the full-width result.
  always_comb begin
    in_entry_c.result    = bus.i_result;
    in_entry_c.flags     = {bus.i_result[N-1], (bus.i_result == '0),
                            bus.i_carry, bus.i_overflow};
    in_entry_c.set_flags = bus.i_set_flags;
  end

  // Next-state, buffer movement and retirement bookkeeping.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    nzcv_d  = nzcv_q;
    count_d = count_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire_c) begin
          state_d = ONE;
          main_d  = in_entry_c;
        end
      end
      ONE: begin
        if (in_fire_c && out_fire_c) begin
          main_d = in_entry_c;
        end else if (in_fire_c) begin
          state_d = FULL;
          skid_d  = in_entry_c;
        end else if (out_fire_c) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // o_ready is low here, so only the drain side can move.
        if (out_fire_c) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // The main entry is always the one retiring.
    if (out_fire_c) begin
      count_d = count_q + CNT_W'(1);
      if (main_q.set_flags) begin
        nzcv_d = main_q.flags;
      end
    end
  end

  // State and output registers; ready/valid look one state ahead.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      nzcv_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      nzcv_q  <= nzcv_d;
      count_q <= count_d;
      ready_q <= (state_d != FULL);
      valid_q <= (state_d != EMPTY);
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_result = main_q.result;
  assign bus.o_flags  = main_q.flags;
  assign bus.o_nzcv   = nzcv_q;
  assign bus.o_count  = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus a random
// run, checked against a queue-based reference model of the result stage.
module tb_alu_result_stage;

  localparam int unsigned N       = 64;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned CNT_W_S = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_result_stage_if #(.N(N), .CNT_W(CNT_W))   bus ();
  alu_result_stage_if #(.N(N), .CNT_W(CNT_W_S)) bus_w ();

  alu_result_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  alu_result_stage #(.N(N), .CNT_W(CNT_W_S)) dut_w (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_w)
  );

  typedef struct {
    logic [N-1:0] r;
    logic [3:0]   f;
    logic         s;
  } exp_t;

  exp_t             mq[$];
  logic [3:0]       m_nzcv;
  logic [CNT_W-1:0] m_count;
  logic             m_ready;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [3:0] flags_of(input logic [N-1:0] r, input logic c, input logic v);
    return {r[N-1], (r == '0), c, v};
  endfunction

  function automatic logic [N-1:0] rand_result();
    logic [N-1:0] x;
    x = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       x = '0;
      1:       x[N-1] = 1'b1;
      default: ;
    endcase
    return x;
  endfunction

  // Drive one cycle on the main instance and advance the model at the edge.
  task automatic step(input logic v, input logic [N-1:0] r, input logic c,
                      input logic o, input logic s, input logic rdy);
    logic in_f;
    logic out_f;
    exp_t e;
    bus.i_valid     = v;
    bus.i_result    = r;
    bus.i_carry     = c;
    bus.i_overflow  = o;
    bus.i_set_flags = s;
    bus.i_ready     = rdy;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_nzcv  = '0;
      m_count = '0;
      m_ready = 1'b0;
    end else begin
      in_f  = v && m_ready;
      out_f = (mq.size() != 0) && rdy;
      if (out_f) begin
        e = mq.pop_front();
        m_count = m_count + 1;
        if (e.s) m_nzcv = e.f;
      end
      if (in_f) begin
        e.r = r;
        e.f = flags_of(r, c, o);
        e.s = s;
        mq.push_back(e);
      end
      m_ready = (mq.size() < 2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 64'h1234, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 64'h5678, 1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", bus.o_ready); end
    n_cmp++; if (bus.o_result !== '0) begin n_err++; $display("FAIL reset_result got %h want 0", bus.o_result); end
    n_cmp++; if (bus.o_flags !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b want 0", bus.o_flags); end
    n_cmp++; if (bus.o_nzcv !== 4'b0) begin n_err++; $display("FAIL reset_nzcv got %b want 0", bus.o_nzcv); end
    n_cmp++; if (bus.o_count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.o_count); end
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset got %b want 1", bus.o_ready); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL valid_after_reset got %b want 0", bus.o_valid); end
  endtask

  task automatic test_single_beat();
    step(1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", bus.o_valid); end
    n_cmp++; if (bus.o_result !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL single_result got %h want 8000000000000000", bus.o_result); end
    n_cmp++; if (bus.o_flags !== 4'b1010) begin n_err++; $display("FAIL single_flags got %b want 1010", bus.o_flags); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.o_nzcv !== 4'b1010) begin n_err++; $display("FAIL single_nzcv got %b want 1010", bus.o_nzcv); end
    n_cmp++; if (bus.o_count !== 32'd1) begin n_err++; $display("FAIL single_count got %0d want 1", bus.o_count); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL single_drained got %b want 0", bus.o_valid); end
  endtask

  task automatic test_zero_no_flags();
    step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.o_flags !== 4'b0100) begin n_err++; $display("FAIL zero_flags got %b want 0100", bus.o_flags); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.o_nzcv !== 4'b1010) begin n_err++; $display("FAIL zero_nzcv_hold got %b want 1010", bus.o_nzcv); end
    n_cmp++; if (bus.o_count !== 32'd2) begin n_err++; $display("FAIL zero_count got %0d want 2", bus.o_count); end
  endtask

  task automatic test_backpressure();
    step(1'b1, 64'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got %b want 1", bus.o_ready); end
    step(1'b1, 64'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got %b want 0", bus.o_ready); end
    n_cmp++; if (bus.o_result !== 64'h11) begin n_err++; $display("FAIL bp_head got %h want 11", bus.o_result); end
    step(1'b1, 64'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.o_result !== 64'h11 || bus.o_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold got %h/%b want 11/1", bus.o_result, bus.o_valid); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.o_result !== 64'h22) begin n_err++; $display("FAIL bp_second got %h want 22", bus.o_result); end
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after got %b want 1", bus.o_ready); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_count !== 32'd4) begin n_err++; $display("FAIL bp_count got %0d want 4", bus.o_count); end
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] c0;
    c0 = m_count;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, N'(i), 1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (bus.o_result !== N'(i) || bus.o_valid !== 1'b1) begin n_err++; $display("FAIL stream_out[%0d] got %h/%b want %h/1", i, bus.o_result, bus.o_valid, N'(i)); end
      n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d] got %b want 1", i, bus.o_ready); end
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.o_count !== c0 + 32'd8) begin n_err++; $display("FAIL stream_count got %0d want %0d", bus.o_count, c0 + 32'd8); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 3) != 0), rand_result(), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom_range(0, 2) != 0));
      n_cmp++; if (bus.o_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rand_valid[%0d] got %b want %b", k, bus.o_valid, mq.size() != 0); end
      n_cmp++; if (bus.o_ready !== m_ready) begin n_err++; $display("FAIL rand_ready[%0d] got %b want %b", k, bus.o_ready, m_ready); end
      if (mq.size() != 0) begin
        n_cmp++; if (bus.o_result !== mq[0].r || bus.o_flags !== mq[0].f) begin n_err++; $display("FAIL rand_data[%0d] got %h/%b want %h/%b", k, bus.o_result, bus.o_flags, mq[0].r, mq[0].f); end
      end
      n_cmp++; if (bus.o_nzcv !== m_nzcv) begin n_err++; $display("FAIL rand_nzcv[%0d] got %b want %b", k, bus.o_nzcv, m_nzcv); end
      n_cmp++; if (bus.o_count !== m_count) begin n_err++; $display("FAIL rand_count[%0d] got %0d want %0d", k, bus.o_count, m_count); end
    end
    while (mq.size() != 0) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 64'hAA, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 64'hBB, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL mid_full_ready got %b want 0", bus.o_ready); end
    rst_n = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_count !== '0) begin n_err++; $display("FAIL mid_count got %0d want 0", bus.o_count); end
    n_cmp++; if (bus.o_nzcv !== 4'b0) begin n_err++; $display("FAIL mid_nzcv got %b want 0", bus.o_nzcv); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin n_err++; $display("FAIL mid_recover got %b/%b want 1/0", bus.o_ready, bus.o_valid); end
  endtask

  task automatic test_counter_wrap();
    bus_w.i_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      bus_w.i_valid    = 1'b1;
      bus_w.i_result   = N'(i);
      bus_w.i_set_flags = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (i == 17) begin
        n_cmp++; if (bus_w.o_count !== 4'd0) begin n_err++; $display("FAIL wrap_at16 got %0d want 0", bus_w.o_count); end
      end
    end
    bus_w.i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus_w.o_count !== CNT_W_S'(17)) begin n_err++; $display("FAIL wrap_count got %0d want 1", bus_w.o_count); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_w.i_valid     = 1'b0;
    bus_w.i_result    = '0;
    bus_w.i_carry     = 1'b0;
    bus_w.i_overflow  = 1'b0;
    bus_w.i_set_flags = 1'b0;
    bus_w.i_ready     = 1'b1;
    m_ready = 1'b0;
    m_nzcv  = '0;
    m_count = '0;
    @(negedge clk);
    test_reset();
    test_single_beat();
    test_zero_no_flags();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
